// File: rtl/cactus_draw_pkg.sv
// Shared screen geometry, colours and FSM encoding for the cactus redraw path.
package cactus_draw_pkg;

   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   localparam int GROUND_Y = 200;
   localparam int CACTUS_W = 10;

   localparam logic [15:0] CACTUS_COLOR = 16'h07E0;
   localparam logic [15:0] BG_COLOR     = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      ERASE1,
      ERASE2,
      DRAW1,
      DRAW2,
      DONE
   } state_t;

   typedef struct packed {
      logic [8:0] left;
      logic [8:0] height;
   } box_t;

   // Boxes taller than the ground line are cut off at the top of the screen.
   function automatic logic [7:0] clamp_h(input logic [8:0] h);
      return (h > 9'(GROUND_Y)) ? 8'(GROUND_Y) : h[7:0];
   endfunction

endpackage

// File: rtl/box_raster.sv
// Scans one CACTUS_W-wide box row by row, issuing one pixel write per accepted
// handshake; off-screen columns are stepped over without a write.
module box_raster
   import cactus_draw_pkg::*;
(
   input  logic        clk,
   input  logic        nRst,
   input  logic        start,
   input  logic [8:0]  left,
   input  logic [7:0]  top,
   input  logic [7:0]  height,
   input  logic [15:0] color,
   input  logic        wr_ready,
   output logic        wr_valid,
   output logic [8:0]  wr_x,
   output logic [7:0]  wr_y,
   output logic [15:0] wr_color,
   output logic        done
);

   localparam logic [8:0] SCR_W    = 9'(SCREEN_W);
   localparam logic [3:0] LAST_COL = 4'(CACTUS_W - 1);

   logic       busy;
   logic [8:0] box_left;
   logic [3:0] col_off;
   logic [7:0] last_y;
   logic [8:0] next_x;
   logic       advance;

   assign next_x  = wr_x + 9'd1;
   assign advance = busy && (!wr_valid || wr_ready);

   always_ff @(posedge clk) begin
      if (!nRst) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         wr_valid <= 1'b0;
         wr_x     <= '0;
         wr_y     <= '0;
         wr_color <= '0;
         box_left <= '0;
         col_off  <= '0;
         last_y   <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            box_left <= left;
            col_off  <= '0;
            wr_x     <= left;
            wr_y     <= top;
            last_y   <= top + height - 8'd1;
            wr_color <= color;
            if (height == 8'd0) begin
               busy     <= 1'b0;
               done     <= 1'b1;
               wr_valid <= 1'b0;
            end else begin
               busy     <= 1'b1;
               wr_valid <= (left < SCR_W);
            end
         end else if (advance) begin
            if (col_off != LAST_COL) begin
               col_off  <= col_off + 4'd1;
               wr_x     <= next_x;
               wr_valid <= (next_x < SCR_W);
            end else if (wr_y != last_y) begin
               col_off  <= '0;
               wr_x     <= box_left;
               wr_y     <= wr_y + 8'd1;
               wr_valid <= (box_left < SCR_W);
            end else begin
               busy     <= 1'b0;
               done     <= 1'b1;
               wr_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/cactus_draw.sv
// Redraws the two cactus boxes: erases the previously drawn pair, then draws
// the newly latched pair, all through one shared box rasterizer.
//
// state  | meaning
// IDLE   | waiting for cactusMovement
// LATCH  | capture new boxes, launch first box
// ERASE1 | old box 1 in background colour
// ERASE2 | old box 2 in background colour
// DRAW1  | new box 1 in cactus colour
// DRAW2  | new box 2 in cactus colour
// DONE   | pulse done, new boxes become old boxes
module cactus_draw
   import cactus_draw_pkg::*;
(
   input  logic        clk,
   input  logic        nRst,
   input  logic        cactusMovement,
   input  logic [8:0]  pixel,
   input  logic [8:0]  x_dist,
   input  logic [8:0]  height1,
   input  logic [8:0]  height2,
   output logic        drawDoneCactus,
   output logic        wr_valid,
   input  logic        wr_ready,
   output logic [8:0]  wr_x,
   output logic [7:0]  wr_y,
   output logic [15:0] wr_color
);

   state_t      state;
   box_t        new1, new2, old1, old2;
   box_t        rast_box;
   logic        prev_valid;
   logic        rast_start;
   logic [15:0] rast_color;
   logic [7:0]  rast_h;
   logic [7:0]  rast_top;
   logic        rast_done;

   assign rast_h   = clamp_h(rast_box.height);
   assign rast_top = 8'(GROUND_Y) - rast_h;

   always_ff @(posedge clk) begin
      if (!nRst) begin
         state          <= IDLE;
         new1           <= '0;
         new2           <= '0;
         old1           <= '0;
         old2           <= '0;
         prev_valid     <= 1'b0;
         rast_box       <= '0;
         rast_color     <= '0;
         rast_start     <= 1'b0;
         drawDoneCactus <= 1'b0;
      end else begin
         rast_start     <= 1'b0;
         drawDoneCactus <= 1'b0;
         case (state)
            IDLE: begin
               if (cactusMovement) state <= LATCH;
            end
            LATCH: begin
               new1       <= '{left: pixel, height: height1};
               new2       <= '{left: pixel - x_dist, height: height2};
               rast_start <= 1'b1;
               if (prev_valid) begin
                  rast_box   <= old1;
                  rast_color <= BG_COLOR;
                  state      <= ERASE1;
               end else begin
                  rast_box   <= '{left: pixel, height: height1};
                  rast_color <= CACTUS_COLOR;
                  state      <= DRAW1;
               end
            end
            ERASE1: begin
               if (rast_done) begin
                  rast_box   <= old2;
                  rast_color <= BG_COLOR;
                  rast_start <= 1'b1;
                  state      <= ERASE2;
               end
            end
            ERASE2: begin
               if (rast_done) begin
                  rast_box   <= new1;
                  rast_color <= CACTUS_COLOR;
                  rast_start <= 1'b1;
                  state      <= DRAW1;
               end
            end
            DRAW1: begin
               if (rast_done) begin
                  rast_box   <= new2;
                  rast_color <= CACTUS_COLOR;
                  rast_start <= 1'b1;
                  state      <= DRAW2;
               end
            end
            DRAW2: begin
               if (rast_done) begin
                  drawDoneCactus <= 1'b1;
                  state          <= DONE;
               end
            end
            DONE: begin
               old1       <= new1;
               old2       <= new2;
               prev_valid <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   box_raster u_raster (
      .clk      (clk),
      .nRst     (nRst),
      .start    (rast_start),
      .left     (rast_box.left),
      .top      (rast_top),
      .height   (rast_h),
      .color    (rast_color),
      .wr_ready (wr_ready),
      .wr_valid (wr_valid),
      .wr_x     (wr_x),
      .wr_y     (wr_y),
      .wr_color (wr_color),
      .done     (rast_done)
   );

endmodule

// File: tb/tb_cactus_draw.sv
// Scoreboard bench for cactus_draw: expected pixel writes are queued per redraw
// and popped as the DUT transfers them.
module tb_cactus_draw;

   logic        clk = 1'b0;
   logic        nRst = 1'b0;
   logic        cactusMovement = 1'b0;
   logic [8:0]  pixel = '0;
   logic [8:0]  x_dist = '0;
   logic [8:0]  height1 = '0;
   logic [8:0]  height2 = '0;
   logic        wr_ready = 1'b1;
   logic        drawDoneCactus;
   logic        wr_valid;
   logic [8:0]  wr_x;
   logic [7:0]  wr_y;
   logic [15:0] wr_color;

   always #5 clk = ~clk;

   cactus_draw dut (
      .clk            (clk),
      .nRst           (nRst),
      .cactusMovement (cactusMovement),
      .pixel          (pixel),
      .x_dist         (x_dist),
      .height1        (height1),
      .height2        (height2),
      .drawDoneCactus (drawDoneCactus),
      .wr_valid       (wr_valid),
      .wr_ready       (wr_ready),
      .wr_x           (wr_x),
      .wr_y           (wr_y),
      .wr_color       (wr_color)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [32:0] exp_q[$];
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          ready_mode = 0;
   logic        prev_stall = 1'b0;
   logic [33:0] prev_out = '0;

   logic       m_prev;
   logic [8:0] m_o1l, m_o1h, m_o2l, m_o2h;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0)      wr_ready = 1'b1;
         else if (ready_mode == 1) wr_ready = 1'($urandom_range(0, 1));
         else                      wr_ready = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (prev_stall && nRst)
         chk("stall_hold", {wr_valid, wr_x, wr_y, wr_color}, prev_out);
      prev_stall = wr_valid && !wr_ready && nRst;
      prev_out   = {wr_valid, wr_x, wr_y, wr_color};
      if (drawDoneCactus) done_cnt++;
      if (nRst && wr_valid && wr_ready) begin
         wr_cnt++;
         chk("write_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0)
            chk("write", {wr_x, wr_y, wr_color}, exp_q.pop_front());
      end
   end

   task automatic push_box(input logic [8:0] left, input logic [8:0] h,
                           input logic [15:0] col, inout int n);
      int hc;
      logic [8:0] x;
      hc = (h > 200) ? 200 : int'(h);
      for (int y = 200 - hc; y < 200; y++) begin
         for (int c = 0; c < 10; c++) begin
            x = left + 9'(c);
            if (x < 320) begin
               exp_q.push_back({x, 8'(y), col});
               n++;
            end
         end
      end
   endtask

   task automatic redraw(input logic [8:0] p, input logic [8:0] xd,
                         input logic [8:0] h1, input logic [8:0] h2,
                         input int abort_after);
      int n;
      int base_w;
      int base_d;
      logic [8:0] b2;
      n  = 0;
      b2 = p - xd;
      if (m_prev) begin
         push_box(m_o1l, m_o1h, 16'hFFFF, n);
         push_box(m_o2l, m_o2h, 16'hFFFF, n);
      end
      push_box(p, h1, 16'h07E0, n);
      push_box(b2, h2, 16'h07E0, n);
      base_w = wr_cnt;
      base_d = done_cnt;

      @(posedge clk); #1;
      pixel = p; x_dist = xd; height1 = h1; height2 = h2;
      cactusMovement = 1'b1;
      @(posedge clk); #1;
      cactusMovement = 1'b0;
      @(posedge clk); #1;
      // inputs wander after the latch; the redraw must not follow them
      pixel = 9'h1A5; x_dist = 9'h033; height1 = 9'h077; height2 = 9'h0C1;
      @(posedge clk);
      @(negedge clk);
      chk("first_valid_latency", wr_valid, 1);

      if (abort_after == 0) begin
         for (int i = 0; i < 20000 && done_cnt == base_d; i++) @(negedge clk);
         repeat (5) @(negedge clk);
         chk("done_pulses", done_cnt - base_d, 1);
         chk("wr_count", wr_cnt - base_w, n);
         chk("queue_drained", exp_q.size(), 0);
         m_prev = 1'b1;
         m_o1l = p;  m_o1h = h1;
         m_o2l = b2; m_o2h = h2;
      end else begin
         for (int i = 0; i < 20000 && (wr_cnt - base_w) < abort_after; i++) @(negedge clk);
         chk("abort_reached", (wr_cnt - base_w) >= abort_after, 1);
         #1;
         ready_mode = 2;
         wr_ready   = 1'b0;
         nRst       = 1'b0;
         exp_q.delete();
         base_d = done_cnt;
         repeat (2) @(negedge clk);
         chk("mid_reset_outs", {wr_valid, drawDoneCactus, wr_x, wr_y, wr_color}, 0);
         #1;
         nRst       = 1'b1;
         ready_mode = 0;
         wr_ready   = 1'b1;
         base_w     = wr_cnt;
         repeat (30) @(negedge clk);
         chk("no_write_after_reset", wr_cnt - base_w, 0);
         chk("no_done_after_reset", done_cnt - base_d, 0);
         m_prev = 1'b0;
         m_o1l = '0; m_o1h = '0; m_o2l = '0; m_o2h = '0;
      end
   endtask

   initial begin
      m_prev = 1'b0;
      m_o1l = '0; m_o1h = '0; m_o2l = '0; m_o2h = '0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {wr_valid, drawDoneCactus, wr_x, wr_y, wr_color}, 0);
      #1 nRst = 1'b1;
      repeat (2) @(negedge clk);

      redraw(9'd100, 9'd30,  9'd15,  9'd20, 0);
      redraw(9'd101, 9'd30,  9'd15,  9'd20, 0);
      redraw(9'd100, 9'd130, 9'd15,  9'd20, 0);
      redraw(9'd315, 9'd30,  9'd15,  9'd20, 0);
      redraw(9'd200, 9'd50,  9'd250, 9'd0,  0);

      ready_mode = 1;
      redraw(9'd100, 9'd30, 9'd15, 9'd20, 0);
      ready_mode = 0;

      redraw(9'd60, 9'd30, 9'd15, 9'd20, 40);
      redraw(9'd50, 9'd20, 9'd10, 9'd5,  0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cactus_draw.md
CACTUS_DRAW -- requirements
Module: cactus_draw

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-low.
REQ-002 SHALL have port clk  input  1  system clock, rising edge.
REQ-003 SHALL have port nRst  input  1  synchronous active-low reset.
REQ-004 SHALL have port cactusMovement  input  1  level request; high means cactus position or shape changed and a redraw is pending.
REQ-005 SHALL have port pixel  input  9  cactus-1 left column, unsigned, modulo 512.
REQ-006 SHALL have port x_dist  input  9  spacing from cactus 1 back to cactus 2.
REQ-007 SHALL have ports height1, height2  input  9  box heights in pixels.
REQ-008 SHALL have port drawDoneCactus  output  1  one-cycle pulse when a redraw completes.
REQ-009 SHALL have port wr_valid  output  1  pixel-write request.
REQ-010 SHALL have port wr_ready  input  1  downstream display accepts the write.
REQ-011 SHALL have ports wr_x  output  9,  wr_y  output  8,  wr_color  output  16 (RGB565).

Function
REQ-012 SHALL implement FSM states IDLE, LATCH, ERASE1, ERASE2, DRAW1, DRAW2, DONE.
REQ-013 SHALL leave IDLE for LATCH in the cycle after cactusMovement is sampled high; otherwise it SHALL stay in IDLE.
REQ-014 In LATCH it SHALL capture the new boxes: box1 left = pixel, box2 left = (pixel - x_dist) mod 512, heights = height1/height2, width = CACTUS_W.
REQ-015 SHALL keep the previously drawn boxes (old1/old2) plus a prev_valid flag.
REQ-016 SHALL visit ERASE1, ERASE2 (using old boxes, BG_COLOR), then DRAW1, DRAW2 (using new boxes, CACTUS_COLOR), then DONE.
REQ-017 SHALL skip both ERASE states entirely when prev_valid=0.
REQ-018 SHALL cover each box as rows y = GROUND_Y-h .. GROUND_Y-1 (top to bottom), with columns left .. left+CACTUS_W-1 (left to right) inside each row.
REQ-019 SHALL compute column addresses modulo 512.
REQ-020 SHALL step past any column >= SCREEN_W (320) without issuing a write.
REQ-021 SHALL pass through a box with h=0 in one cycle with no writes.
REQ-022 SHALL clamp h > GROUND_Y to GROUND_Y.
REQ-023 SHALL hold wr_valid, wr_x, wr_y, wr_color stable while wr_valid=1 and wr_ready=0.
REQ-024 SHALL treat a write as transferred only on a cycle with wr_valid=1 and wr_ready=1, and then advance to the next pixel in the following cycle.
REQ-025 SHALL assert the first wr_valid of a redraw no later than 2 cycles after entering LATCH.
REQ-026 SHALL sustain one write per cycle while wr_ready stays high.
REQ-027 In DONE it SHALL pulse drawDoneCactus for exactly one cycle, copy new boxes into old1/old2, set prev_valid=1, and return to IDLE.
REQ-028 SHALL ignore changes on pixel, x_dist, height1 and height2 after LATCH until the next LATCH.
REQ-029 If cactusMovement is still high in IDLE after DONE, it SHALL start a new redraw, since the upstream stage re-asserts it on a position change coinciding with done.
REQ-030 SHALL hold wr_valid=0 in IDLE, LATCH and DONE.

Reset
REQ-031 On nRst=0 at a clock edge, the block SHALL go to IDLE with wr_valid=0, drawDoneCactus=0, wr_x=0, wr_y=0, wr_color=0, prev_valid=0 and old boxes zeroed.
REQ-032 Reset mid-redraw SHALL abandon the redraw immediately, with no further writes or done pulse.
REQ-033 The first redraw after reset SHALL perform no erase.

Structure
REQ-034 A shared package SHALL hold SCREEN_W=320, SCREEN_H=240, GROUND_Y=200, CACTUS_W=10, CACTUS_COLOR=16'h07E0, BG_COLOR=16'hFFFF and the FSM state enum.
REQ-035 A single sub-module box_raster SHALL provide the scanner.
REQ-036 box_raster SHALL take inputs start, left, top, height, color and wr_ready, and SHALL produce outputs wr_valid, wr_x, wr_y, wr_color and busy/done.
REQ-037 box_raster SHALL be instantiated once and reused for all four boxes.

Verification
REQ-038 Scenario: reset, pixel=100, x_dist=30, height1=15, height2=20, wr_ready=1, cactusMovement=1 -> no erase; 150 writes at x 100..109, y 185..199 in CACTUS_COLOR; then 200 writes at x 70..79, y 180..199; then one drawDoneCactus pulse.
REQ-039 Scenario: follow-up with pixel=101 -> 350 BG_COLOR writes of the old boxes precede 350 draw writes shifted by +1 in x.
REQ-040 Scenario: pixel=100, x_dist=130 -> box2 left=482, off-screen, so box2 produces zero writes and done still pulses.
REQ-041 Scenario: pixel=315, height1=15 -> only columns 315..319 are written (75 writes).
REQ-042 Scenario: wr_ready toggled randomly (50%) -> outputs stay stable while stalled, no write is lost or duplicated, and the total count matches the wr_ready=1 run.
REQ-043 Scenario: nRst asserted after 40 writes, then a new request -> no further writes or done pulse before the request, and the new redraw performs no erase.
